// File: rtl/char_loader.sv
`timescale 1ns/1ps
// Host write port for the 50x30 text display character RAM: synchronizes the async strobe,
// settles and samples the bus, validates it and issues one-cycle RAM writes.
// Optional screen fill command is built when CHAR_LOADER_FILL_EN is defined.
module char_loader #(
    parameter int COLS          = 50,
    parameter int ROWS          = 30,
    parameter int NUM_GLYPHS    = 59,
    parameter int SETTLE_CYCLES = 2,
    parameter int FILL_ADDR     = 2047
) (
    input  logic        clk_20mhz,
    input  logic        rst_n,
    input  logic [10:0] addr_in,
    input  logic [5:0]  char_in,
    input  logic        interrupt,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [5:0]  wr_data,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int          CELLS       = COLS * ROWS;
    localparam logic [10:0] LAST_CELL   = 11'(CELLS - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    localparam logic [2:0] ST_WAIT_LOW = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_WRITE    = 3'd4;
`ifdef CHAR_LOADER_FILL_EN
    localparam logic [2:0] ST_FILL     = 3'd5;
`endif

    logic        s1_q, s2_q;
    logic [2:0]  state_q, state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [10:0] addr_lat_q, addr_lat_d;
    logic [5:0]  char_lat_q, char_lat_d;
    logic        wr_en_q, wr_en_d;
    logic [10:0] wr_addr_q, wr_addr_d;
    logic [5:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        addr_ok, code_ok;

    assign addr_ok = (int'(addr_lat_q) < CELLS);
    assign code_ok = (int'(char_lat_q) < NUM_GLYPHS);

`ifdef CHAR_LOADER_FILL_EN
    logic fill_cmd;
    assign fill_cmd = (int'(addr_lat_q) == FILL_ADDR);
`else
    // Without the fill feature the fill address is just another out-of-range address.
    logic unused_fill_addr;
    assign unused_fill_addr = (int'(addr_lat_q) == FILL_ADDR);
`endif

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        addr_lat_d   = addr_lat_q;
        char_lat_d   = char_lat_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_count_d  = err_count_q;
        case (state_q)
            ST_WAIT_LOW: begin
                if (!s2_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (s2_q) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                // The bus is only trusted once the strobe has been high for the settle window.
                if (settle_cnt_q == SETTLE_LAST) begin
                    addr_lat_d = addr_in;
                    char_lat_d = char_in;
                    state_d    = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (addr_ok && code_ok) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_lat_q;
                    wr_data_d = char_lat_q;
                end
`ifdef CHAR_LOADER_FILL_EN
                else if (fill_cmd && code_ok) begin
                    state_d   = ST_FILL;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = char_lat_q;
                end
`endif
                else begin
                    state_d = ST_WAIT_LOW;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                end
            end
            ST_WRITE: begin
                state_d = ST_WAIT_LOW;
            end
`ifdef CHAR_LOADER_FILL_EN
            ST_FILL: begin
                if (wr_addr_q == LAST_CELL) begin
                    state_d = ST_WAIT_LOW;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 11'd1;
                end
            end
`endif
            default: begin
                state_d = ST_WAIT_LOW;
            end
        endcase
        busy_d = (state_d != ST_WAIT_LOW) && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_20mhz) begin
        if (!rst_n) begin
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            state_q      <= ST_WAIT_LOW;
            settle_cnt_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            err_count_q  <= '0;
        end else begin
            s1_q         <= interrupt;
            s2_q         <= s1_q;
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            err_count_q  <= err_count_d;
        end
    end

    // Latched bus value is only consumed after SETTLE, so it needs no reset.
    always_ff @(posedge clk_20mhz) begin
        addr_lat_q <= addr_lat_d;
        char_lat_q <= char_lat_d;
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign err_count = err_count_q;

endmodule
